signed_divider: RTL and testbench

SIGNED_DIVIDER -- requirements
Module: signed_divider

---
 rtl/div_pkg.sv | 20 ++
 rtl/add_sub.sv | 17 +
 rtl/signed_divider.sv | 158 +++++++++++++++
 tb/tb_signed_divider.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the signed divider: FSM state encoding,
// default operand width and iteration-counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    // Counter width able to hold every value 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/add_sub.sv
// Combinational W-bit adder/subtractor. With sub=1 the B operand is
// inverted and a carry of one is injected, giving a - b.
module add_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    logic [W-1:0] b_eff;

    assign b_eff = b ^ {W{sub}};
    assign sum   = a + b_eff + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/signed_divider.sv
// Multi-cycle signed divider. Operands are reduced to magnitudes, divided
// with an unsigned non-restoring loop (one bit per cycle), then the
// remainder is corrected and signs are re-applied. Quotient truncates
// toward zero; remainder takes the sign of the dividend.
module signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int AW    = WIDTH + 1;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    div_state_e state, state_nxt;

    // Partial remainder (signed, one guard bit), shifting quotient register,
    // divisor magnitude and the bookkeeping latched at start.
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH-1:0] dsr_mag;
    logic [CNT_W-1:0] cnt;
    logic             sgn_q;
    logic             sgn_r;
    logic             ovf_pend;

    // Operand conditioning at request time. The magnitude of the most
    // negative value is 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dsr_mag_in;
    logic             dsr_zero;
    logic             is_ovf;
    logic             last_iter;

    assign dvd_mag_in = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign dsr_mag_in = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign dsr_zero   = (divisor == '0);
    assign is_ovf     = (dividend == MIN_NEG) && (divisor == ALL_ONES);
    assign last_iter  = (cnt == CNT_W'(WIDTH - 1));

    // Single shared adder: CALC uses it for the shifted add/subtract step,
    // CORR uses it to add the divisor back to a negative remainder.
    logic [AW-1:0] as_a;
    logic [AW-1:0] as_b;
    logic          as_sub;
    logic [AW-1:0] as_sum;
    logic [AW-1:0] rem_fix;

    assign as_b = {1'b0, dsr_mag};

    // Select adder operands for the current phase.
    always_comb begin
        as_a   = acc;
        as_sub = 1'b0;
        if (state == CALC) begin
            as_a   = {acc[AW-2:0], quo_sh[WIDTH-1]};
            as_sub = ~acc[AW-1];
        end
    end

    add_sub #(
        .W (AW)
    ) u_add_sub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .sum (as_sum)
    );

    assign rem_fix = acc[AW-1] ? as_sum : acc;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = dsr_zero ? DONE : CALC;
            CALC:    if (last_iter) state_nxt = CORR;
            CORR:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and result registers; results hold until the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc         <= '0;
            quo_sh      <= '0;
            dsr_mag     <= '0;
            cnt         <= '0;
            sgn_q       <= 1'b0;
            sgn_r       <= 1'b0;
            ovf_pend    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        cnt      <= '0;
                        quo_sh   <= dvd_mag_in;
                        dsr_mag  <= dsr_mag_in;
                        sgn_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sgn_r    <= dividend[WIDTH-1];
                        ovf_pend <= is_ovf;
                        if (dsr_zero) begin
                            quotient    <= ALL_ONES;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    acc    <= as_sum;
                    quo_sh <= {quo_sh[WIDTH-2:0], ~as_sum[AW-1]};
                    cnt    <= cnt + 1'b1;
                end
                CORR: begin
                    acc         <= rem_fix;
                    quotient    <= sgn_q ? (~quo_sh + 1'b1) : quo_sh;
                    remainder   <= sgn_r ? (~rem_fix[WIDTH-1:0] + 1'b1)
                                         : rem_fix[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    overflow    <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: the driver pushes expected results
// (from plain integer division) when a start is accepted; a monitor pops
// and compares whenever done is seen, and checks busy/hold behaviour.
module tb_signed_divider;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         overflow;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int accepted = 0;

    exp_t sb[$];

    logic [W-1:0] dir_a [12] = '{8'd100, 8'h9C, 8'd100, 8'h80, 8'h80, 8'd5,
                                 8'd0,   8'd127, 8'h80, 8'hFF, 8'h80, 8'd7};
    logic [W-1:0] dir_b [12] = '{8'd7,   8'd7,  8'hF9,  8'hFF, 8'd1,  8'd0,
                                 8'd5,   8'h80, 8'h80,  8'd0,  8'd0,  8'd100};

    signed_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference: truncating integer division on sign-extended operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int ai, bi, qi, ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        e.dz = 1'b0; e.ov = 1'b0; e.cyc = 0;
        if (bi == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            qi   = ai / bi;
            ri   = ai % bi;
            e.q  = qi[W-1:0];
            e.r  = ri[W-1:0];
            e.ov = (qi > (2 ** (W - 1)) - 1);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 8'h80;
            1:       return 8'hFF;
            2:       return 8'h00;
            3:       return 8'h01;
            default: return W'($urandom);
        endcase
    endfunction

    // Drive one cycle of inputs (called at a negedge); record acceptance.
    task automatic step(input logic st, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        start    = st;
        dividend = a;
        divisor  = b;
        if (st && !busy && rst_n) begin
            e     = model(a, b);
            e.cyc = cyc + 1 + (e.dz ? 0 : W + 1);
            sb.push_back(e);
            accepted++;
        end
        @(negedge clk);
    endtask

    // Wait out any operation with random start noise, then issue one request.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (busy && n < 40) begin
            step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
            n++;
        end
        if (busy) chk("busy_stuck", {31'd0, busy}, 32'd0);
        step(1'b1, a, b);
    endtask

    // Stimulus.
    initial begin
        int target;
        int guard;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_op(dir_a[i], dir_b[i]);

        // Abort in the 4th CALC cycle, then a clean 50/5.
        run_op(8'd77, 8'd3);
        repeat (3) step(1'b0, 8'd0, 8'd0);
        rst_n = 1'b0;
        sb.delete();
        step(1'b0, 8'd0, 8'd0);
        rst_n = 1'b1;
        run_op(8'd50, 8'd5);

        repeat (800) run_op(rnd_operand(), rnd_operand());

        // start held high: every IDLE cycle accepts, busy cycles ignore it.
        target = accepted + 1500;
        guard  = 0;
        while (accepted < target && guard < 30000) begin
            step(1'b1, rnd_operand(), rnd_operand());
            guard++;
        end

        repeat (15) step(1'b0, 8'd0, 8'd0);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: sampled 1 time unit after each rising edge.
    initial begin
        exp_t         e;
        logic [W-1:0] last_q, last_r;
        logic         last_dz, last_ov;
        last_q = '0; last_r = '0; last_dz = 1'b0; last_ov = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc > 90000) begin
                $display("FAIL watchdog cycle=%0d", cyc);
                $fatal(1, "watchdog expired");
            end
            if (!rst_n) begin
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_quotient", {24'd0, quotient}, 32'd0);
                chk("rst_remainder", {24'd0, remainder}, 32'd0);
                chk("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
                chk("rst_overflow", {31'd0, overflow}, 32'd0);
                last_q = '0; last_r = '0; last_dz = 1'b0; last_ov = 1'b0;
            end else if (done) begin
                chk("busy_with_done", {31'd0, busy}, 32'd1);
                if (sb.size() == 0) begin
                    chk("spurious_done", {31'd0, done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("quotient", {24'd0, quotient}, {24'd0, e.q});
                    chk("remainder", {24'd0, remainder}, {24'd0, e.r});
                    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                    chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
                    last_q = e.q; last_r = e.r; last_dz = e.dz; last_ov = e.ov;
                end
            end else if (sb.size() != 0) begin
                chk("busy_running", {31'd0, busy}, 32'd1);
                if (cyc >= sb[0].cyc) begin
                    chk("done_missing", {31'd0, done}, 32'd1);
                    void'(sb.pop_front());
                end
            end else begin
                chk("idle_busy", {31'd0, busy}, 32'd0);
                chk("hold_quotient", {24'd0, quotient}, {24'd0, last_q});
                chk("hold_remainder", {24'd0, remainder}, {24'd0, last_r});
                chk("hold_div_by_zero", {31'd0, div_by_zero}, {31'd0, last_dz});
                chk("hold_overflow", {31'd0, overflow}, {31'd0, last_ov});
            end
        end
    end

endmodule
